// File: rtl/lat_mem.sv
// rtl/lat_mem.sv - split I/D simulation memory with per-port cache-miss emulation
// lat_mem_port is one port's presence-tag table, fill FSM and miss statistics.
module lat_mem_port #(
  parameter int MEM_WORDS      = 4096,
  parameter int LINE_WORDS     = 4,
  parameter int LINES          = 16,
  parameter int MISS_LAT       = 8,
  parameter int TRD_W          = 3,
  parameter int HIT_UNDER_MISS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [31:0]      addr,
  input  logic [TRD_W-1:0] trd,
  output logic             hit,
  output logic             miss,
  output logic             segfault,
  output logic [TRD_W-1:0] fill_trd,
  output logic [31:0]      miss_cnt
);
  localparam int          OFF_W          = $clog2(LINE_WORDS);
  localparam int          IDX_W          = $clog2(LINES);
  localparam int          TAG_W          = 30 - OFF_W - IDX_W;
  localparam logic [32:0] BYTES          = 33'(MEM_WORDS) * 33'd4;
  localparam logic [7:0]  LAT_M1         = (MISS_LAT == 0) ? 8'd0 : 8'(MISS_LAT - 1);
  localparam bit          ALWAYS_PRESENT = (MISS_LAT == 0);
  localparam bit          HUM_EN         = (HIT_UNDER_MISS != 0);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           state, next_state;
  logic [7:0]       cnt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             legal, table_hit, done_hit, hit_raw, start, done;

  assign idx   = addr[2+OFF_W +: IDX_W];
  assign tag   = addr[31 -: TAG_W];
  assign legal = req && (addr[1:0] == 2'b00) && ({1'b0, addr} < BYTES);

  assign table_hit = valid[idx] && (tags[idx] == tag);
  // The line whose fill completes this cycle is already visible to its requester.
  assign done_hit  = (state == FILL) && (cnt == 8'd0) && (idx == fill_idx) && (tag == fill_tag);
  assign hit_raw   = legal && (ALWAYS_PRESENT || done_hit ||
                               (table_hit && ((state == IDLE) || HUM_EN)));

  assign hit      = rst_n && hit_raw;
  assign miss     = rst_n && legal && !hit_raw;
  assign segfault = rst_n && req && !legal;

  always_comb begin
    next_state = state;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (legal && !hit_raw) begin
        start      = 1'b1;
        next_state = FILL;
      end
      FILL: if (cnt == 8'd0) begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      valid    <= '0;
      fill_idx <= '0;
      fill_tag <= '0;
      fill_trd <= '0;
      miss_cnt <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        cnt      <= LAT_M1;
        fill_idx <= idx;
        fill_tag <= tag;
        fill_trd <= trd;
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end else if ((state == FILL) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      if (done) valid[fill_idx] <= 1'b1;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (done) tags[fill_idx] <= fill_tag;
  end
endmodule

module lat_mem #(
  parameter string INIT_FILE      = "",
  parameter int    MEM_WORDS      = 4096,
  parameter int    LINE_WORDS     = 4,
  parameter int    LINES          = 16,
  parameter int    MISS_LAT       = 8,
  parameter int    TRD_W          = 3,
  parameter int    HIT_UNDER_MISS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      i_addr,
  input  logic             i_rd,
  input  logic [TRD_W-1:0] i_trd,
  output logic [31:0]      i_rd_data,
  output logic             i_miss,
  output logic             i_segfault,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wr_data,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic [TRD_W-1:0] d_trd,
  output logic [31:0]      d_rd_data,
  output logic             d_miss,
  output logic             d_segfault,
  output logic [TRD_W-1:0] i_fill_trd,
  output logic [TRD_W-1:0] d_fill_trd,
  output logic [31:0]      i_miss_cnt,
  output logic [31:0]      d_miss_cnt
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];
  logic        i_hit, d_hit, d_req;

  assign d_req = d_rd | d_wr;

  lat_mem_port #(
    .MEM_WORDS(MEM_WORDS), .LINE_WORDS(LINE_WORDS), .LINES(LINES),
    .MISS_LAT(MISS_LAT), .TRD_W(TRD_W), .HIT_UNDER_MISS(HIT_UNDER_MISS)
  ) u_iport (
    .clk(clk), .rst_n(rst_n), .req(i_rd), .addr(i_addr), .trd(i_trd),
    .hit(i_hit), .miss(i_miss), .segfault(i_segfault),
    .fill_trd(i_fill_trd), .miss_cnt(i_miss_cnt)
  );

  lat_mem_port #(
    .MEM_WORDS(MEM_WORDS), .LINE_WORDS(LINE_WORDS), .LINES(LINES),
    .MISS_LAT(MISS_LAT), .TRD_W(TRD_W), .HIT_UNDER_MISS(HIT_UNDER_MISS)
  ) u_dport (
    .clk(clk), .rst_n(rst_n), .req(d_req), .addr(d_addr), .trd(d_trd),
    .hit(d_hit), .miss(d_miss), .segfault(d_segfault),
    .fill_trd(d_fill_trd), .miss_cnt(d_miss_cnt)
  );

  // Reads are combinational, so a same-cycle store is seen by neither port until the next cycle.
  assign i_rd_data = i_hit ? mem[i_addr[AW+1:2]] : 32'd0;
  assign d_rd_data = d_hit ? mem[d_addr[AW+1:2]] : 32'd0;

  always_ff @(posedge clk) begin
    if (d_hit && d_wr) mem[d_addr[AW+1:2]] <= d_wr_data;
  end
endmodule

// File: tb/tb_lat_mem.sv
// tb/tb_lat_mem.sv - scoreboard bench for lat_mem against a line-level reference model
// Three configurations: (8 cyc, hit-under-miss), (3 cyc, no hit-under-miss, small lines), (hit-only).
module tb_lat_mem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wr_data = '0;
  logic        i_rd = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [2:0]  i_trd = '0, d_trd = '0;

  logic [31:0] i_rd_data [3], d_rd_data [3], i_miss_cnt [3], d_miss_cnt [3];
  logic        i_miss [3], i_segfault [3], d_miss [3], d_segfault [3];
  logic [2:0]  i_fill_trd [3], d_fill_trd [3];

  always #5 clk = ~clk;

  lat_mem #(.MISS_LAT(8), .HIT_UNDER_MISS(1), .LINES(16), .LINE_WORDS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data[0]), .i_miss(i_miss[0]), .i_segfault(i_segfault[0]),
    .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data[0]), .d_miss(d_miss[0]), .d_segfault(d_segfault[0]),
    .i_fill_trd(i_fill_trd[0]), .d_fill_trd(d_fill_trd[0]),
    .i_miss_cnt(i_miss_cnt[0]), .d_miss_cnt(d_miss_cnt[0]));

  lat_mem #(.MISS_LAT(3), .HIT_UNDER_MISS(0), .LINES(8), .LINE_WORDS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data[1]), .i_miss(i_miss[1]), .i_segfault(i_segfault[1]),
    .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data[1]), .d_miss(d_miss[1]), .d_segfault(d_segfault[1]),
    .i_fill_trd(i_fill_trd[1]), .d_fill_trd(d_fill_trd[1]),
    .i_miss_cnt(i_miss_cnt[1]), .d_miss_cnt(d_miss_cnt[1]));

  lat_mem #(.MISS_LAT(0), .HIT_UNDER_MISS(1), .LINES(16), .LINE_WORDS(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .i_rd_data(i_rd_data[2]), .i_miss(i_miss[2]), .i_segfault(i_segfault[2]),
    .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
    .d_rd_data(d_rd_data[2]), .d_miss(d_miss[2]), .d_segfault(d_segfault[2]),
    .i_fill_trd(i_fill_trd[2]), .d_fill_trd(d_fill_trd[2]),
    .i_miss_cnt(i_miss_cnt[2]), .d_miss_cnt(d_miss_cnt[2]));

  function automatic int ml(input int k);  return (k == 0) ? 8 : (k == 1) ? 3 : 0; endfunction
  function automatic bit hum(input int k); return k != 1;                           endfunction
  function automatic int nl(input int k);  return (k == 1) ? 8 : 16;                endfunction
  function automatic int lw(input int k);  return (k == 1) ? 2 : 4;                 endfunction

  typedef struct packed {
    int          k;
    int          cyc;
    logic [31:0] i_data, d_data, i_mc, d_mc;
    logic [2:0]  i_ft, d_ft;
    bit          i_dk, d_dk, i_miss, i_seg, d_miss, d_seg;
  } exp_t;

  exp_t sb [$];
  int   checks = 0, failures = 0, cyc = 0;

  // Reference state: which line each port holds at each index, plus the one pending fill.
  int          pres  [3][2][16];
  bit          busy  [3][2];
  int          fend  [3][2];
  int          fline [3][2];
  logic [2:0]  ftrd  [3][2];
  logic [31:0] mcnt  [3][2];
  logic [31:0] mm    [3][4096];
  bit          known [3][4096];

  task automatic model_reset(input int k);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) pres[k][p][i] = -1;
      busy[k][p] = 0;
      ftrd[k][p] = '0;
      mcnt[k][p] = '0;
    end
  endtask

  task automatic port_eval(input int k, input int p, input bit req, input logic [31:0] addr,
                           input logic [2:0] trd, output bit hit, output bit miss, output bit seg);
    bit legal, done;
    int line, idx;
    legal = req && (addr[1:0] == 2'b00) && (addr < 32'h4000);
    seg   = req && !legal;
    line  = int'(addr >> 2) / lw(k);
    idx   = line % nl(k);
    done  = busy[k][p] && (cyc == fend[k][p]);
    if (ml(k) == 0) hit = legal;
    else hit = legal && ((pres[k][p][idx] == line && (!busy[k][p] || hum(k))) ||
                         (done && line == fline[k][p]));
    miss = legal && !hit;
    if (done) begin
      pres[k][p][fline[k][p] % nl(k)] = fline[k][p];
      busy[k][p] = 0;
    end else if (miss && !busy[k][p]) begin
      busy[k][p]  = 1;
      fend[k][p]  = cyc + ml(k);
      fline[k][p] = line;
      ftrd[k][p]  = trd;
      if (mcnt[k][p] != 32'hFFFF_FFFF) mcnt[k][p] = mcnt[k][p] + 1;
    end
  endtask

  task automatic drive(input bit rst, input bit ird, input logic [31:0] ia, input logic [2:0] it,
                       input bit drd, input bit dwr, input logic [31:0] da, input logic [31:0] dw,
                       input logic [2:0] dt, output bit d_all_hit);
    exp_t e;
    bit ih, im, is, dh, dm, ds;
    rst_n = !rst; i_rd = ird; i_addr = ia; i_trd = it;
    d_rd = drd; d_wr = dwr; d_addr = da; d_wr_data = dw; d_trd = dt;
    d_all_hit = 1;
    for (int k = 0; k < 3; k++) begin
      e = '0;
      e.k = k; e.cyc = cyc; e.i_dk = 1; e.d_dk = 1;
      if (rst) begin
        model_reset(k);
        d_all_hit = 0;
      end else begin
        e.i_ft = ftrd[k][0]; e.i_mc = mcnt[k][0];
        e.d_ft = ftrd[k][1]; e.d_mc = mcnt[k][1];
        port_eval(k, 0, ird, ia, it, ih, im, is);
        port_eval(k, 1, drd | dwr, da, dt, dh, dm, ds);
        e.i_miss = im; e.i_seg = is; e.d_miss = dm; e.d_seg = ds;
        if (ih) begin e.i_data = mm[k][ia[13:2]]; e.i_dk = known[k][ia[13:2]]; end
        if (dh) begin e.d_data = mm[k][da[13:2]]; e.d_dk = known[k][da[13:2]]; end
        if (dh && dwr) begin mm[k][da[13:2]] = dw; known[k][da[13:2]] = 1; end
        if (!dh) d_all_hit = 0;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input int k, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("i_miss",     e.k, e.cyc, 32'(i_miss[e.k]),     32'(e.i_miss));
        chk("i_segfault", e.k, e.cyc, 32'(i_segfault[e.k]), 32'(e.i_seg));
        chk("d_miss",     e.k, e.cyc, 32'(d_miss[e.k]),     32'(e.d_miss));
        chk("d_segfault", e.k, e.cyc, 32'(d_segfault[e.k]), 32'(e.d_seg));
        chk("i_fill_trd", e.k, e.cyc, 32'(i_fill_trd[e.k]), 32'(e.i_ft));
        chk("d_fill_trd", e.k, e.cyc, 32'(d_fill_trd[e.k]), 32'(e.d_ft));
        chk("i_miss_cnt", e.k, e.cyc, i_miss_cnt[e.k],      e.i_mc);
        chk("d_miss_cnt", e.k, e.cyc, d_miss_cnt[e.k],      e.d_mc);
        if (e.i_dk) chk("i_rd_data", e.k, e.cyc, i_rd_data[e.k], e.i_data);
        if (e.d_dk) chk("d_rd_data", e.k, e.cyc, d_rd_data[e.k], e.d_data);
      end
    end
  end

  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 78)      return 32'($urandom_range(0, 127)) << 2;
    else if (r < 84) return 32'($urandom_range(192, 255)) << 2;
    else if (r < 89) return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
    else if (r < 93) return 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
    else if (r < 95) return 32'hFFFF_FFFC;
    else             return 32'h3FFC;
  endfunction

  initial begin
    bit          ok;
    logic [31:0] ia;
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      for (int w = 0; w < 4096; w++) begin mm[k][w] = '0; known[k][w] = 0; end
    end
    @(negedge clk);
    for (int n = 0; n < 3; n++)
      drive(1, 1, 32'h10, 3'd5, 1, 1, 32'h40, 32'h1, 3'd2, ok);

    // Preload words 0..127 through the D port, retrying each store until every config accepts it.
    for (int w = 0; w < 128; w++) begin
      logic [31:0] v;
      int          tries;
      v = $urandom;
      ok = 0;
      tries = 0;
      while (!ok && tries < 20) begin
        drive(0, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 127)) << 2, 3'($urandom_range(0, 7)),
              0, 1, 32'(w) << 2, v, 3'($urandom_range(0, 7)), ok);
        tries++;
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL preload_timeout word=%0d actual=miss required=hit within 20 cycles", w);
      end
    end

    drive(0, 0, 0, 0, 1, 0, 32'h4000, 0, 3'd1, ok);
    drive(0, 0, 0, 0, 0, 1, 32'h2, 32'hBAD0BAD0, 3'd1, ok);
    drive(0, 0, 0, 0, 1, 0, 32'h0, 0, 3'd1, ok);
    drive(0, 0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 3'd3, ok);
    drive(0, 0, 0, 0, 1, 0, 32'h80, 0, 3'd3, ok);
    for (int n = 0; n < 12; n++) drive(0, 1, 32'h2000, 3'd6, 0, 0, 0, 0, 0, ok);
    for (int n = 0; n < 12; n++) drive(0, 1, 32'h80, 3'd4, 0, 0, 0, 0, 0, ok);
    // Abort a fill three cycles in, then hold the same request across the full penalty.
    for (int n = 0; n < 3; n++) drive(0, 1, 32'h3000, 3'd7, 0, 0, 0, 0, 0, ok);
    for (int n = 0; n < 2; n++) drive(1, 1, 32'h3000, 3'd7, 0, 0, 0, 0, 0, ok);
    for (int n = 0; n < 12; n++) drive(0, 1, 32'h3000, 3'd7, 0, 0, 0, 0, 0, ok);

    ia = pick();
    for (int n = 0; n < 3000; n++) begin
      int dsel;
      if ($urandom_range(0, 1) == 0) ia = pick();
      dsel = $urandom_range(0, 3);
      drive($urandom_range(0, 599) == 0, $urandom_range(0, 9) < 7, ia, 3'($urandom_range(0, 7)),
            dsel[0], dsel[1], pick(), $urandom, 3'($urandom_range(0, 7)), ok);
    end

    #5;
    chk("sb_drain", 0, cyc, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
